// File: rtl/st_video_timing_if.sv
// ---------------------------------------------------------------------------
// st_video_timing_if
//
// Groups the bus-side signals of the ST video timing generator.
//
//   base_we      screen base write strobe (one clock wide)
//   base_data    new screen base, word address (byte address bits 21:1)
//   de           display enable towards the shifter
//   load_n       active-low word load strobe towards the shifter
//   hsync_n      active-low horizontal sync
//   vsync_n      active-low vertical sync
//   vid_addr     word address of the next word the shifter will load
//   frame_start  one-clock pulse at the beginning of each frame
//
// Modports:
//   master  the timing generator (drives raster outputs, receives base writes)
//   slave   the surrounding system (writes the base, consumes the raster)
// ---------------------------------------------------------------------------
interface st_video_timing_if;
    logic        base_we;
    logic [20:0] base_data;
    logic        de;
    logic        load_n;
    logic        hsync_n;
    logic        vsync_n;
    logic [20:0] vid_addr;
    logic        frame_start;

    modport master (
        input  base_we,
        input  base_data,
        output de,
        output load_n,
        output hsync_n,
        output vsync_n,
        output vid_addr,
        output frame_start
    );

    modport slave (
        output base_we,
        output base_data,
        input  de,
        input  load_n,
        input  hsync_n,
        input  vsync_n,
        input  vid_addr,
        input  frame_start
    );
endinterface

// File: rtl/st_video_timing.sv
// ---------------------------------------------------------------------------
// st_video_timing
//
// Raster timing generator for the ST video path. Runs horizontal and
// vertical counters at the 32 MHz shifter clock and derives display enable,
// the shifter word-load strobe, both syncs, a frame start pulse and the DMA
// word address of the word being loaded.
//
// Ports:
//   CLOCK_32  in   shifter master clock, rising edge active
//   reset_n   in   asynchronous active-low reset
//   vif       master side of st_video_timing_if:
//               base_we/base_data in, de/load_n/hsync_n/vsync_n/
//               vid_addr/frame_start out
//
// Every output is a flop fed from the current counter value, so outputs lag
// the counters by one clock. H_TOTAL, H_DE_START and H_DE_LEN are expected
// to be multiples of 16 so that every DE window holds whole 16-clock slots.
// ---------------------------------------------------------------------------
module st_video_timing #(
    parameter int H_TOTAL      = 2048,
    parameter int H_DE_START   = 512,
    parameter int H_DE_LEN     = 1280,
    parameter int H_SYNC_START = 1920,
    parameter int H_SYNC_LEN   = 150,
    parameter int V_TOTAL      = 313,
    parameter int V_DE_START   = 63,
    parameter int V_DE_LINES   = 200,
    parameter int V_SYNC_START = 310,
    parameter int V_SYNC_LEN   = 3
) (
    input  logic               CLOCK_32,
    input  logic               reset_n,
    st_video_timing_if.master  vif
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = 21;

    // Raster counters
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // Cleared by reset; keeps the very first h=0/v=0 cycle after reset from
    // counting as a frame start, so the first pulse comes one frame later.
    logic          started_q, started_d;

    // Registered outputs
    logic          de_q, de_d;
    logic          load_n_q, load_n_d;
    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;
    logic          frame_start_q, frame_start_d;
    logic [AW-1:0] vid_addr_q, vid_addr_d;
    logic [AW-1:0] base_pending_q, base_pending_d;

    // Decode of the current counter position
    int            h_i;
    int            v_i;
    logic [3:0]    slot;
    logic          h_wrap;
    logic          v_wrap;
    logic          line_vis;
    logic          h_in_de;
    logic          de_now;
    logic          load_now;
    logic          frame_origin;

    always_comb begin
        h_i          = int'(h_q);
        v_i          = int'(v_q);

        // Slot phase relative to the DE start; only the low nibble matters
        // because slots are 16 clocks long.
        slot         = h_q[3:0] - 4'(H_DE_START);

        h_wrap       = (h_i == H_TOTAL - 1);
        v_wrap       = (v_i == V_TOTAL - 1);
        line_vis     = (v_i >= V_DE_START) && (v_i < V_DE_START + V_DE_LINES);
        h_in_de      = (h_i >= H_DE_START) && (h_i < H_DE_START + H_DE_LEN);
        de_now       = line_vis && h_in_de;
        load_now     = de_now && (slot >= 4'd12);
        frame_origin = (h_q == '0) && (v_q == '0) && started_q;

        // Counter advance
        h_d       = h_wrap ? '0 : h_q + 1'b1;
        v_d       = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + 1'b1;
        end
        started_d = 1'b1;

        // Output decode. Sync windows are deliberately not masked by DE.
        de_d          = de_now;
        load_n_d      = !load_now;
        hsync_n_d     = !((h_i >= H_SYNC_START) && (h_i < H_SYNC_START + H_SYNC_LEN));
        vsync_n_d     = !((v_i >= V_SYNC_START) && (v_i < V_SYNC_START + V_SYNC_LEN));
        frame_start_d = frame_origin;

        // A write takes effect only at the next frame origin; the origin cycle
        // itself still sees the old pending value because both update on the
        // same edge.
        base_pending_d = vif.base_we ? vif.base_data : base_pending_q;

        // The address advances on the edge where the load strobe returns
        // high, so it is constant for the whole low period of a load and
        // names the word being loaded. It runs on across lines and wraps
        // naturally at 2^21.
        vid_addr_d = vid_addr_q;
        if (frame_origin) begin
            vid_addr_d = base_pending_q;
        end else if (!load_n_q && !load_now) begin
            vid_addr_d = vid_addr_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_32 or negedge reset_n) begin
        if (!reset_n) begin
            h_q            <= '0;
            v_q            <= '0;
            started_q      <= 1'b0;
            de_q           <= 1'b0;
            load_n_q       <= 1'b1;
            hsync_n_q      <= 1'b1;
            vsync_n_q      <= 1'b1;
            frame_start_q  <= 1'b0;
            vid_addr_q     <= '0;
            base_pending_q <= '0;
        end else begin
            h_q            <= h_d;
            v_q            <= v_d;
            started_q      <= started_d;
            de_q           <= de_d;
            load_n_q       <= load_n_d;
            hsync_n_q      <= hsync_n_d;
            vsync_n_q      <= vsync_n_d;
            frame_start_q  <= frame_start_d;
            vid_addr_q     <= vid_addr_d;
            base_pending_q <= base_pending_d;
        end
    end

    assign vif.de          = de_q;
    assign vif.load_n      = load_n_q;
    assign vif.hsync_n     = hsync_n_q;
    assign vif.vsync_n     = vsync_n_q;
    assign vif.frame_start = frame_start_q;
    assign vif.vid_addr    = vid_addr_q;

endmodule

// File: tb/tb_st_video_timing.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_st_video_timing
//
// Scoreboard bench for st_video_timing using a reduced raster so that many
// frames fit in a short run. A reference process predicts each output cycle
// from the elapsed cycle count (position = cycle mod line/frame length) and
// the screen base in force for that frame; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_st_video_timing;

    localparam int HT    = 96;
    localparam int HDS   = 16;
    localparam int HDL   = 64;
    localparam int HSS   = 76;   // overlaps the end of the DE window
    localparam int HSL   = 12;
    localparam int VT    = 24;
    localparam int VDS   = 5;
    localparam int VDL   = 10;
    localparam int VSS   = 20;
    localparam int VSL   = 3;
    localparam int FRAME = HT * VT;
    localparam int WPL   = HDL / 16;

    logic clk;
    logic rst_n;

    st_video_timing_if vif();

    st_video_timing #(
        .H_TOTAL(HT), .H_DE_START(HDS), .H_DE_LEN(HDL),
        .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_DE_START(VDS), .V_DE_LINES(VDL),
        .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .CLOCK_32 (clk),
        .reset_n  (rst_n),
        .vif      (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic        de;
        logic        load_n;
        logic        hsync_n;
        logic        vsync_n;
        logic        frame_start;
        logic [20:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    int          n = 0;          // rising edges since reset release
    logic [20:0] pending = '0;   // base value most recently written
    logic [20:0] fbase   = '0;   // base in force for the current frame
    int          checks  = 0;
    int          errors  = 0;

    // Expected outputs after the edge that closes raster cycle c.
    function automatic exp_t predict(input int c, input logic [20:0] fb);
        exp_t e;
        int   hc, vc, lines, words;
        logic vis;
        hc    = c % HT;
        vc    = (c / HT) % VT;
        vis   = (vc >= VDS) && (vc < VDS + VDL);
        e.c   = c;
        e.de  = vis && (hc >= HDS) && (hc < HDS + HDL);
        e.load_n      = !(e.de && (((hc - HDS) % 16) >= 12));
        e.hsync_n     = !((hc >= HSS) && (hc < HSS + HSL));
        e.vsync_n     = !((vc >= VSS) && (vc < VSS + VSL));
        e.frame_start = (c > 0) && (hc == 0) && (vc == 0);
        if (vc < VDS)            lines = 0;
        else if (vc >= VDS + VDL) lines = VDL;
        else                     lines = vc - VDS;
        // Words whose load has finished on this line so far.
        words = 0;
        if (vis && hc >= HDS + 16) words = (hc - HDS) / 16;
        if (words > WPL) words = WPL;
        e.addr = fb + 21'(lines * WPL + words);
        return e;
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
        end
    endtask

    // Reference model: advances one raster cycle per rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            n       = 0;
            pending = '0;
            fbase   = '0;
            sb_q.delete();
        end else begin
            int c;
            c = n;
            n = n + 1;
            if (c > 0 && (c % FRAME) == 0) fbase = pending;
            sb_q.push_back(predict(c, fbase));
            if (vif.base_we) pending = vif.base_data;
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_de",          -1, 32'(vif.de),          32'd0);
            chk("rst_load_n",      -1, 32'(vif.load_n),      32'd1);
            chk("rst_hsync_n",     -1, 32'(vif.hsync_n),     32'd1);
            chk("rst_vsync_n",     -1, 32'(vif.vsync_n),     32'd1);
            chk("rst_frame_start", -1, 32'(vif.frame_start), 32'd0);
            chk("rst_vid_addr",    -1, 32'(vif.vid_addr),    32'd0);
        end else if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("de",          e.c, 32'(vif.de),          32'(e.de));
            chk("load_n",      e.c, 32'(vif.load_n),      32'(e.load_n));
            chk("hsync_n",     e.c, 32'(vif.hsync_n),     32'(e.hsync_n));
            chk("vsync_n",     e.c, 32'(vif.vsync_n),     32'(e.vsync_n));
            chk("frame_start", e.c, 32'(vif.frame_start), 32'(e.frame_start));
            chk("vid_addr",    e.c, 32'(vif.vid_addr),    32'(e.addr));
        end
    end

    // Pulse base_we for one clock during raster cycle 'target'.
    task automatic write_at(input int target, input logic [20:0] d);
        while (n < target) @(negedge clk);
        vif.base_we   = 1'b1;
        vif.base_data = d;
        @(negedge clk);
        vif.base_we   = 1'b0;
        vif.base_data = 21'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d limit_ns=%0d", n, 2_000_000);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int c_rst;
        rst_n         = 1'b0;
        vif.base_we   = 1'b0;
        vif.base_data = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Frame 0: random base mid-frame, takes effect in frame 1.
        write_at(FRAME / 2 + $urandom_range(0, FRAME / 4), 21'($urandom));
        // Frame 1: base 0x01F000 mid-frame, used from frame 2.
        write_at(FRAME + FRAME / 3, 21'h01F000);
        // Frame 2: random base mid-frame.
        write_at(2 * FRAME + $urandom_range(100, FRAME - 100), 21'($urandom));
        // Write coincident with the frame 3 origin: frame 3 keeps the old base.
        write_at(3 * FRAME, 21'h000100);
        // Base near the top of memory: frame 5 addresses wrap through zero.
        write_at(4 * FRAME + 500, 21'h1FFFF8);
        // Frame 5: a burst of random writes, the last one wins for frame 6.
        t = 5 * FRAME + 200;
        for (int k = 0; k < 4; k++) begin
            t = t + $urandom_range(50, 400);
            write_at(t, 21'($urandom));
        end

        // Asynchronous reset in a visible line while a load is in progress.
        c_rst = 6 * FRAME + 7 * HT + HDS + 16 + 13;
        while (n < c_rst) @(negedge clk);
        #1;
        chk("pre_rst_load_n", c_rst, 32'(vif.load_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_load_n",   c_rst, 32'(vif.load_n),      32'd1);
        chk("async_de",       c_rst, 32'(vif.de),          32'd0);
        chk("async_vid_addr", c_rst, 32'(vif.vid_addr),    32'd0);
        chk("async_hsync_n",  c_rst, 32'(vif.hsync_n),     32'd1);
        chk("async_vsync_n",  c_rst, 32'(vif.vsync_n),     32'd1);
        chk("async_fstart",   c_rst, 32'(vif.frame_start), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Run past the first vsync and the first frame start after restart.
        while (n < FRAME + 6 * HT) @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
